// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core.
// Drives the memory handshakes, gates the decoder's write strobes and picks the next-PC source.
module core_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  input  logic        dec_reg_we,
  input  logic        dec_mem_we,
  input  logic [1:0]  dec_sel_data_in,
  input  logic [1:0]  dec_pc_is_branch,
  input  logic        dec_pc_is_jmp,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        bus_error,
  output logic [2:0]  state_o,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_IDLE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instret_q, instret_d;

  logic is_load, timeout_hit, req, rdy;

  assign is_load     = (dec_sel_data_in == 2'b01);
  // Expires on the last allowed waiting cycle; a ready in that cycle still wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LAST);

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    bus_error = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (dec_mem_we || is_load) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_we;
        if (dmem_ready) begin
          mdr_we  = is_load;
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        rf_we     = dec_reg_we & ~dec_mem_we;
        pc_we     = 1'b1;
        instret_d = instret_q + 32'd1;
        if (dec_pc_is_branch == 2'b01)      pc_sel = 2'b01;
        else if (dec_pc_is_branch == 2'b10) pc_sel = 2'b10;
        else if (dec_pc_is_jmp && branch_taken) pc_sel = 2'b11;
        state_d = halt ? S_IDLE : S_FETCH;
      end
      S_IDLE:   if (!halt) state_d = S_FETCH;
      S_ERROR:  bus_error = 1'b1;
      default:  state_d = S_ERROR;
    endcase
  end

  assign req = imem_req | dmem_req;
  assign rdy = (imem_req & imem_ready) | (dmem_req & dmem_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (req && !rdy) cnt_d = cnt_q + 1'b1;
    if (rdy) cnt_d = '0;
    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  assign state_o = state_q;
  assign instret = instret_q;

endmodule
